// File: rtl/rib_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rib_arb2
// Description : Two-master round-robin arbiter sharing one RIB slave path
//               between m0 (core LSU) and m1 (DMA). Address phases are
//               forwarded with zero added latency. A 1-bit owner FIFO
//               records which master owns each accepted-but-unanswered
//               transaction, so in-order slave responses reach the right
//               master.
// Ports       : i_clk, i_rst          clock, synchronous active-high reset
//               i_mN_*                 master request fields / req / rdy
//               o_mN_gnt, o_mN_rsp     master grant / response valid
//               o_mN_rdata             slave read data (qualify with rsp)
//               o_ribs_*               forwarded request towards the slave
//               i_ribs_gnt/rsp/rdata   slave grant / response / read data
//               o_ribs_rdy             ready back to the slave
//               o_busy                 outstanding transactions exist
//               o_err_orphan           response seen with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module rib_arb2 #(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_m0_addr,
    input  logic        i_m0_wrcs,
    input  logic [3:0]  i_m0_mask,
    input  logic [31:0] i_m0_wdata,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m0_req,
    output logic        o_m0_gnt,
    output logic        o_m0_rsp,
    input  logic        i_m0_rdy,
    input  logic [31:0] i_m1_addr,
    input  logic        i_m1_wrcs,
    input  logic [3:0]  i_m1_mask,
    input  logic [31:0] i_m1_wdata,
    output logic [31:0] o_m1_rdata,
    input  logic        i_m1_req,
    output logic        o_m1_gnt,
    output logic        o_m1_rsp,
    input  logic        i_m1_rdy,
    output logic [31:0] o_ribs_addr,
    output logic        o_ribs_wrcs,
    output logic [3:0]  o_ribs_mask,
    output logic [31:0] o_ribs_wdata,
    input  logic [31:0] i_ribs_rdata,
    output logic        o_ribs_req,
    input  logic        i_ribs_gnt,
    input  logic        i_ribs_rsp,
    output logic        o_ribs_rdy,
    output logic        o_busy,
    output logic        o_err_orphan
);

    localparam int              c_PTR_W = $clog2(MAX_OUTST);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(MAX_OUTST);

    // Registered state
    logic                 last_q,     last_d;
    logic                 lock_q,     lock_d;
    logic                 lock_sel_q, lock_sel_d;
    logic [c_PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [MAX_OUTST-1:0] fifo_q,     fifo_d;

    // Combinational
    logic w_arb_sel;
    logic w_sel;
    logic w_sel_req;
    logic w_nonempty;
    logic w_full;
    logic w_head;
    logic w_head_rdy;
    logic w_pop;
    logic w_allow;
    logic w_push;

    // Round-robin choice; with nobody requesting the value is don't-care (0).
    always_comb begin
        w_arb_sel = 1'b0;
        if (i_m0_req && i_m1_req) begin
            w_arb_sel = ~last_q;
        end else if (i_m1_req) begin
            w_arb_sel = 1'b1;
        end
    end

    // A stalled address phase keeps its master until it is granted.
    assign w_sel     = lock_q ? lock_sel_q : w_arb_sel;
    assign w_sel_req = w_sel ? i_m1_req : i_m0_req;

    assign w_nonempty = (cnt_q != '0);
    assign w_full     = (cnt_q == c_FULL);
    assign w_head     = fifo_q[rd_ptr_q];
    assign w_head_rdy = w_head ? i_m1_rdy : i_m0_rdy;

    // With nothing outstanding the slave is drained (any response is an orphan).
    assign o_ribs_rdy = ~i_rst & (w_nonempty ? w_head_rdy : 1'b1);
    assign w_pop      = i_ribs_rsp & o_ribs_rdy & w_nonempty;

    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign w_allow    = ~w_full | w_pop;
    assign o_ribs_req = ~i_rst & w_sel_req & w_allow;
    assign w_push     = o_ribs_req & i_ribs_gnt;

    assign o_m0_gnt = i_ribs_gnt & o_ribs_req & ~w_sel;
    assign o_m1_gnt = i_ribs_gnt & o_ribs_req &  w_sel;

    assign o_ribs_addr  = w_sel ? i_m1_addr  : i_m0_addr;
    assign o_ribs_wrcs  = w_sel ? i_m1_wrcs  : i_m0_wrcs;
    assign o_ribs_mask  = w_sel ? i_m1_mask  : i_m0_mask;
    assign o_ribs_wdata = w_sel ? i_m1_wdata : i_m0_wdata;

    assign o_m0_rsp = ~i_rst & i_ribs_rsp & w_nonempty & ~w_head;
    assign o_m1_rsp = ~i_rst & i_ribs_rsp & w_nonempty &  w_head;

    assign o_m0_rdata = i_ribs_rdata;
    assign o_m1_rdata = i_ribs_rdata;

    assign o_busy       = ~i_rst & w_nonempty;
    assign o_err_orphan = ~i_rst & i_ribs_rsp & ~w_nonempty;

    always_comb begin
        last_d     = last_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        fifo_d     = fifo_q;

        if (w_push) begin
            last_d           = w_sel;
            lock_d           = 1'b0;
            fifo_d[wr_ptr_q] = w_sel;
            wr_ptr_d         = wr_ptr_q + c_PTR_W'(1);
        end else if (o_ribs_req) begin
            lock_d     = 1'b1;
            lock_sel_d = w_sel;
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            fifo_q     <= '0;
        end else begin
            last_q     <= last_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            fifo_q     <= fifo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rib_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_rib_arb2
// Description : Directed self-checking bench for rib_arb2. Inputs change
//               1 ns after the rising edge; outputs are sampled on the
//               falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rib_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_wrcs, m1_wrcs;
    logic [3:0]  m0_mask, m1_mask;
    logic        m0_req, m1_req, m0_gnt, m1_gnt, m0_rsp, m1_rsp, m0_rdy, m1_rdy;
    logic [31:0] ribs_addr, ribs_wdata, ribs_rdata;
    logic        ribs_wrcs, ribs_req, ribs_gnt, ribs_rsp, ribs_rdy;
    logic [3:0]  ribs_mask;
    logic        busy, err_orphan;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rib_arb2 #(.MAX_OUTST(4), .CNT_W(3)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_m0_addr    (m0_addr),
        .i_m0_wrcs    (m0_wrcs),
        .i_m0_mask    (m0_mask),
        .i_m0_wdata   (m0_wdata),
        .o_m0_rdata   (m0_rdata),
        .i_m0_req     (m0_req),
        .o_m0_gnt     (m0_gnt),
        .o_m0_rsp     (m0_rsp),
        .i_m0_rdy     (m0_rdy),
        .i_m1_addr    (m1_addr),
        .i_m1_wrcs    (m1_wrcs),
        .i_m1_mask    (m1_mask),
        .i_m1_wdata   (m1_wdata),
        .o_m1_rdata   (m1_rdata),
        .i_m1_req     (m1_req),
        .o_m1_gnt     (m1_gnt),
        .o_m1_rsp     (m1_rsp),
        .i_m1_rdy     (m1_rdy),
        .o_ribs_addr  (ribs_addr),
        .o_ribs_wrcs  (ribs_wrcs),
        .o_ribs_mask  (ribs_mask),
        .o_ribs_wdata (ribs_wdata),
        .i_ribs_rdata (ribs_rdata),
        .o_ribs_req   (ribs_req),
        .i_ribs_gnt   (ribs_gnt),
        .i_ribs_rsp   (ribs_rsp),
        .o_ribs_rdy   (ribs_rdy),
        .o_busy       (busy),
        .o_err_orphan (err_orphan)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Move to the falling edge of the current cycle for sampling.
    task automatic sample();
        @(negedge clk);
    endtask

    // Advance to the next cycle, 1 ns past the rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; m0_rdy = 0; m1_rdy = 0;
        ribs_gnt = 0; ribs_rsp = 0; ribs_rdata = 32'h0;
    endtask

    initial begin
        rst = 1;
        m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
        m0_wrcs = 0; m1_wrcs = 0; m0_mask = 4'h0; m1_mask = 4'h0;
        idle_inputs();
        // Requests and a response during reset must produce no handshake.
        m0_req = 1; ribs_gnt = 1; ribs_rsp = 1;
        next();
        next();
        sample();
        check("rst_ribs_req", {31'b0, ribs_req}, 32'd0);
        check("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_orphan", {31'b0, err_orphan}, 32'd0);
        check("rst_rdy", {31'b0, ribs_rdy}, 32'd0);
        next();
        rst = 0;
        idle_inputs();

        // ---------------- single master read ----------------
        m0_addr = 32'hf100_0004; m0_wrcs = 0; m0_mask = 4'hF;
        m0_req = 1; ribs_gnt = 1;
        sample();
        check("s_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        check("s_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        check("s_addr", ribs_addr, 32'hf100_0004);
        check("s_busy0", {31'b0, busy}, 32'd0);
        next();
        m0_req = 0; ribs_gnt = 0;
        sample();
        check("s_busy1", {31'b0, busy}, 32'd1);
        check("s_m0_rsp_early", {31'b0, m0_rsp}, 32'd0);
        next();
        ribs_rsp = 1; ribs_rdata = 32'hA5A5_0001; m0_rdy = 1;
        sample();
        check("s_m0_rsp", {31'b0, m0_rsp}, 32'd1);
        check("s_m1_rsp", {31'b0, m1_rsp}, 32'd0);
        check("s_rdata", m0_rdata, 32'hA5A5_0001);
        check("s_rdy", {31'b0, ribs_rdy}, 32'd1);
        check("s_orphan", {31'b0, err_orphan}, 32'd0);
        next();
        idle_inputs();
        sample();
        check("s_busy_end", {31'b0, busy}, 32'd0);

        // ---------------- tie / round robin ----------------
        next();
        m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
        m1_wrcs = 1; m1_mask = 4'h3; m1_wdata = 32'hDEAD_BEEF;
        m0_req = 1; m1_req = 1; ribs_gnt = 1;
        for (int k = 0; k < 4; k++) begin
            sample();
            // last was m0 after the single-master read, so m1 wins first.
            check($sformatf("rr_m1_gnt%0d", k), {31'b0, m1_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr_m0_gnt%0d", k), {31'b0, m0_gnt}, (k % 2 == 0) ? 32'd0 : 32'd1);
            if (k == 0) begin
                check("rr_addr_m1", ribs_addr, 32'h0000_2000);
                check("rr_wdata_m1", ribs_wdata, 32'hDEAD_BEEF);
                check("rr_wrcs_mask_m1", {27'b0, ribs_wrcs, ribs_mask}, 32'h13);
            end
            next();
        end
        m0_req = 0; m1_req = 0; ribs_gnt = 0;
        ribs_rsp = 1; m0_rdy = 1; m1_rdy = 1;
        for (int k = 0; k < 4; k++) begin
            ribs_rdata = 32'h100 + k;
            sample();
            check($sformatf("rr_m1_rsp%0d", k), {31'b0, m1_rsp}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr_m0_rsp%0d", k), {31'b0, m0_rsp}, (k % 2 == 0) ? 32'd0 : 32'd1);
            next();
        end
        idle_inputs();
        sample();
        check("rr_busy_end", {31'b0, busy}, 32'd0);
        check("rr_orphan_end", {31'b0, err_orphan}, 32'd0);

        // ---------------- lock ----------------
        next();
        m0_addr = 32'h0000_A000; m1_addr = 32'h0000_B000;
        m0_req = 1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) m1_req = 1;
            sample();
            check($sformatf("lk_addr%0d", k), ribs_addr, 32'h0000_A000);
            check($sformatf("lk_nogrant%0d", k), {30'b0, m0_gnt, m1_gnt}, 32'd0);
            next();
        end
        ribs_gnt = 1;
        sample();
        check("lk_m0_gnt", {30'b0, m0_gnt, m1_gnt}, 32'b10);
        next();
        m0_req = 0;
        sample();
        check("lk_m1_gnt", {30'b0, m0_gnt, m1_gnt}, 32'b01);
        check("lk_addr_m1", ribs_addr, 32'h0000_B000);
        next();
        m1_req = 0; ribs_gnt = 0; ribs_rsp = 1; m0_rdy = 1; m1_rdy = 1;
        sample();
        check("lk_rsp_a", {30'b0, m0_rsp, m1_rsp}, 32'b10);
        next();
        sample();
        check("lk_rsp_b", {30'b0, m0_rsp, m1_rsp}, 32'b01);
        next();
        idle_inputs();

        // ---------------- full / backpressure ----------------
        m0_addr = 32'h0000_C000; m0_req = 1; ribs_gnt = 1;
        for (int k = 0; k < 4; k++) begin
            sample();
            check($sformatf("fu_gnt%0d", k), {31'b0, m0_gnt}, 32'd1);
            next();
        end
        sample();
        check("fu_req_blocked", {31'b0, ribs_req}, 32'd0);
        check("fu_gnt_blocked", {31'b0, m0_gnt}, 32'd0);
        check("fu_busy", {31'b0, busy}, 32'd1);
        next();
        ribs_rsp = 1; m0_rdy = 1;
        sample();
        check("fu_pop_rsp", {31'b0, m0_rsp}, 32'd1);
        check("fu_pop_req", {31'b0, ribs_req}, 32'd1);
        check("fu_pop_gnt", {31'b0, m0_gnt}, 32'd1);
        next();
        m0_req = 0; ribs_gnt = 0;
        // Four entries must remain: all four drains go to m0, none orphaned.
        for (int k = 0; k < 4; k++) begin
            sample();
            check($sformatf("fu_drain%0d", k), {30'b0, m0_rsp, err_orphan}, 32'b10);
            next();
        end
        idle_inputs();
        sample();
        check("fu_busy_end", {31'b0, busy}, 32'd0);

        // ---------------- orphan ----------------
        next();
        ribs_rsp = 1;
        sample();
        check("or_rdy", {31'b0, ribs_rdy}, 32'd1);
        check("or_flag", {31'b0, err_orphan}, 32'd1);
        check("or_rsps", {30'b0, m0_rsp, m1_rsp}, 32'd0);
        next();
        ribs_rsp = 0;
        sample();
        check("or_flag_off", {31'b0, err_orphan}, 32'd0);
        check("or_busy", {31'b0, busy}, 32'd0);

        // ---------------- reset mid-flight ----------------
        next();
        m0_req = 1; ribs_gnt = 1;
        next();
        next();
        m0_req = 0; ribs_gnt = 0;
        sample();
        check("rm_busy_pre", {31'b0, busy}, 32'd1);
        next();
        rst = 1;
        sample();
        check("rm_busy_in_rst", {31'b0, busy}, 32'd0);
        next();
        rst = 0;
        sample();
        check("rm_busy_post", {31'b0, busy}, 32'd0);
        next();
        ribs_rsp = 1; m0_rdy = 1;
        sample();
        check("rm_orphan", {31'b0, err_orphan}, 32'd1);
        check("rm_m0_rsp", {31'b0, m0_rsp}, 32'd0);
        next();
        ribs_rsp = 0; m0_rdy = 0;
        m1_addr = 32'h0000_D000; m1_req = 1; ribs_gnt = 1;
        sample();
        check("rm_m1_gnt", {30'b0, m0_gnt, m1_gnt}, 32'b01);
        next();
        m1_req = 0; ribs_gnt = 0;
        sample();
        check("rm_busy_new", {31'b0, busy}, 32'd1);
        next();
        ribs_rsp = 1; m1_rdy = 1;
        sample();
        check("rm_m1_rsp", {30'b0, m0_rsp, m1_rsp}, 32'b01);
        next();
        idle_inputs();
        sample();
        check("rm_busy_end", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
